feature_mac_engine: RTL and testbench

Downstream consumer of the 400-word sample/weight register bank written by the HPS over Avalon-MM. On a start pulse it streams a programmable window of words out of the bank's second read port, multiplies the packed signed 16-bit sample by the packed signed 16-bit weight in each word, and accumulates the products. It reports a saturated 32-bit score and a face/no-face flag against a threshold. It is the first compute stage of the detection datapath, and its result is written back into a status register by software.

---
 rtl/face_det_pkg.sv | 9 +
 rtl/feature_mac_pipe.sv | 55 +++++
 rtl/feature_mac_engine.sv | 86 ++++++++
 tb/tb_feature_mac_engine.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/face_det_pkg.sv
// face_det_pkg: shared sizes, MAC FSM states and saturation bounds for the detection datapath
package face_det_pkg;
  localparam int DEPTH  = 400;
  localparam int ADDR_W = 9;
  localparam int ACC_W  = 41;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_S} mac_state_t;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};
endpackage

// File: rtl/feature_mac_pipe.sv
// feature_mac_pipe: product register, clearable accumulator and saturating result stage
module feature_mac_pipe
  import face_det_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        vld,
  input  logic        fin,
  input  logic [31:0] rd_data,
  input  logic [31:0] thresh,
  output logic [31:0] result,
  output logic        sat,
  output logic        face
);
  logic                    v1_q, v1_d, pv_q, pv_d, sat_q, sat_d, face_q, face_d;
  logic signed [31:0]      prod_q, prod_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [31:0]             res_q, res_d, clamp;
  logic                    hi, lo;
  always_comb begin
    v1_d   = vld;
    pv_d   = v1_q;
    prod_d = $signed({{16{rd_data[31]}}, rd_data[31:16]}) * $signed({{16{rd_data[15]}}, rd_data[15:0]});
    acc_d  = clr ? '0 : pv_q ? acc_q + $signed({{(ACC_W-32){prod_q[31]}}, prod_q}) : acc_q;
    hi     = acc_q > SAT_MAX;
    lo     = acc_q < SAT_MIN;
    clamp  = hi ? 32'h7FFF_FFFF : lo ? 32'h8000_0000 : acc_q[31:0];
    res_d  = fin ? clamp : res_q;
    sat_d  = fin ? (hi | lo) : sat_q;
    face_d = fin ? ($signed(clamp) > $signed(thresh)) : face_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      pv_q   <= 1'b0;
      prod_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      sat_q  <= 1'b0;
      face_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      pv_q   <= pv_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
      sat_q  <= sat_d;
      face_q <= face_d;
    end
  end
  assign result = res_q;
  assign sat    = sat_q;
  assign face   = face_q;
endmodule

// File: rtl/feature_mac_engine.sv
// feature_mac_engine: streams a bank window through a signed MAC and scores it against a threshold
module feature_mac_engine
  import face_det_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [ADDR_W-1:0] LEN,
  input  logic [31:0]       THRESH,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [31:0]       RD_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [31:0]       RESULT,
  output logic              SAT,
  output logic              FACE
);
  mac_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [1:0]        drn_q, drn_d;
  logic [31:0]       thr_q, thr_d;
  logic              clr, fin;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    thr_d   = thr_q;
    clr     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        clr     = 1'b1;
        thr_d   = THRESH;
        addr_d  = BASE >= ADDR_W'(DEPTH) ? BASE - ADDR_W'(DEPTH) : BASE;
        cnt_d   = LEN > ADDR_W'(DEPTH) ? ADDR_W'(DEPTH) : LEN;
        drn_d   = 2'd2;
        state_d = LEN == '0 ? DRAIN : RUN;
      end
      RUN: begin
        addr_d  = addr_q == ADDR_W'(DEPTH - 1) ? '0 : addr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == ADDR_W'(1) ? DRAIN : RUN;
      end
      DRAIN: begin
        drn_d   = drn_q - 2'd1;
        fin     = drn_q == 2'd0;
        state_d = drn_q == 2'd0 ? DONE_S : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      thr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      thr_q   <= thr_d;
    end
  end
  assign RD_EN   = state_q == RUN;
  assign RD_ADDR = addr_q;
  assign BUSY    = state_q == RUN || state_q == DRAIN;
  assign DONE    = state_q == DONE_S;
  feature_mac_pipe u_pipe (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clr    (clr),
    .vld    (RD_EN),
    .fin    (fin),
    .rd_data(RD_DATA),
    .thresh (thr_q),
    .result (RESULT),
    .sat    (SAT),
    .face   (FACE)
  );
endmodule

// File: tb/tb_feature_mac_engine.sv
// tb_feature_mac_engine: directed runs against a window-sum model with literal pins
module tb_feature_mac_engine;
  import face_det_pkg::*;
  logic              CLK = 1'b0;
  logic              RESET_N, START, RD_EN, BUSY, DONE, SAT, FACE;
  logic [ADDR_W-1:0] BASE, LEN, RD_ADDR;
  logic [31:0]       THRESH, RD_DATA, RESULT;
  logic [31:0]       mem [DEPTH];
  int                total = 0, bad = 0;
  bit                m_on = 0;
  int                m_cyc, m_base, m_len, done_at;
  logic [31:0]       m_res;
  logic              m_sat, m_face;
  logic [ADDR_W-1:0] addr_log [$];

  feature_mac_engine dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .BASE(BASE), .LEN(LEN),
    .THRESH(THRESH), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .SAT(SAT), .FACE(FACE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (RD_EN) RD_DATA <= mem[RD_ADDR];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void model(input int b, input int l, input logic [31:0] th);
    longint s = 0;
    for (int k = 0; k < l; k++) begin
      logic [31:0] w = mem[(b + k) % DEPTH];
      shortint ws = w[31:16];
      shortint xs = w[15:0];
      s += longint'(ws) * longint'(xs);
    end
    m_sat = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    m_res = s > 64'sd2147483647 ? 32'h7FFF_FFFF : s < -64'sd2147483648 ? 32'h8000_0000 : s[31:0];
    m_face = $signed(m_res) > $signed(th);
  endfunction

  always @(negedge CLK) begin
    if (RESET_N) begin
      if (m_on) begin
        m_cyc++;
        chk("rd_en", 32'(RD_EN), 32'(m_cyc <= m_len));
        if (m_cyc <= m_len) chk("rd_addr", 32'(RD_ADDR), 32'((m_base + m_cyc - 1) % DEPTH));
        if (RD_EN) addr_log.push_back(RD_ADDR);
        chk("busy", 32'(BUSY), 32'(m_cyc <= m_len + 3));
        chk("done", 32'(DONE), 32'(m_cyc == m_len + 4));
        if (DONE && done_at == 0) done_at = m_cyc;
        if (m_cyc == m_len + 4) begin
          chk("result", RESULT, m_res);
          chk("sat", 32'(SAT), 32'(m_sat));
          chk("face", 32'(FACE), 32'(m_face));
          m_on = 0;
        end
      end else begin
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_rd_en", 32'(RD_EN), 32'd0);
        chk("idle_done", 32'(DONE), 32'd0);
      end
    end
  end

  task automatic launch(input int b, input int l, input logic [31:0] th);
    @(posedge CLK);
    #1 START = 1'b1; BASE = ADDR_W'(b); LEN = ADDR_W'(l); THRESH = th;
    @(posedge CLK);
    #1 START = 1'b0; BASE = ADDR_W'($urandom); LEN = ADDR_W'($urandom); THRESH = $urandom;
    m_base = b % DEPTH;
    m_len = l > DEPTH ? DEPTH : l;
    model(m_base, m_len, th);
    addr_log.delete();
    done_at = 0;
    m_cyc = 0;
    m_on = 1;
  endtask

  task automatic go(input int b, input int l, input logic [31:0] th, input bit ign);
    launch(b, l, th);
    for (int c = 1; c <= m_len + 4; c++) begin
      if (ign && (c == 3 || c == m_len + 4)) START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic load_basic();
    mem[0] = {16'h0002, 16'h0003};
    mem[1] = {16'hFFFF, 16'h0005};
    mem[2] = {16'h0004, 16'hFFFE};
    mem[3] = {16'h0000, 16'h0007};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b1; START = 1'b0; BASE = '0; LEN = '0; THRESH = '0; RD_DATA = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #2 RESET_N = 1'b0;
    #2;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_rd_en", 32'(RD_EN), 32'd0);
    chk("rst_rd_addr", 32'(RD_ADDR), 32'd0);
    chk("rst_result", RESULT, 32'd0);
    chk("rst_sat_face", {30'd0, SAT, FACE}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;

    load_basic();
    go(0, 4, 32'd0, 0);
    chk("basic_result", RESULT, 32'hFFFF_FFF9);
    chk("basic_sat_face", {30'd0, SAT, FACE}, 32'd0);
    chk("basic_latency", 32'(done_at - 1), 32'd7);
    chk("basic_nreads", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("basic_addr", 32'(addr_log[i]), 32'(i));

    go(0, 4, 32'd0, 1);
    chk("ign_result", RESULT, 32'hFFFF_FFF9);
    chk("ign_latency", 32'(done_at - 1), 32'd7);
    chk("ign_nreads", 32'(addr_log.size()), 32'd4);

    go(0, 4, 32'hFFFF_FFF8, 0);
    chk("face_below", 32'(FACE), 32'd1);
    go(0, 4, 32'hFFFF_FFF9, 0);
    chk("face_equal", 32'(FACE), 32'd0);

    go(5, 0, 32'd0, 0);
    chk("empty_result", RESULT, 32'd0);
    chk("empty_face", 32'(FACE), 32'd0);
    chk("empty_latency", 32'(done_at - 1), 32'd3);
    chk("empty_nreads", 32'(addr_log.size()), 32'd0);

    mem[398] = {16'h0003, 16'h0004};
    mem[399] = {16'hFFFE, 16'h0006};
    go(398, 4, 32'd0, 0);
    chk("wrap_result", RESULT, 32'd1);
    chk("wrap_nreads", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      chk("wrap_a0", 32'(addr_log[0]), 32'd398);
      chk("wrap_a1", 32'(addr_log[1]), 32'd399);
      chk("wrap_a2", 32'(addr_log[2]), 32'd0);
      chk("wrap_a3", 32'(addr_log[3]), 32'd1);
    end

    for (int i = 0; i < DEPTH; i++) mem[i] = {16'h0001, 16'(i)};
    go(10, 500, 32'd0, 0);
    chk("clamp_nreads", 32'(addr_log.size()), 32'd400);
    chk("clamp_result", RESULT, 32'd79800);

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h7FFF_7FFF;
    go(0, 400, 32'd0, 0);
    chk("satp_result", RESULT, 32'h7FFF_FFFF);
    chk("satp_sat_face", {30'd0, SAT, FACE}, 32'd3);

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h8000_7FFF;
    go(0, 400, 32'd0, 0);
    chk("satn_result", RESULT, 32'h8000_0000);
    chk("satn_sat_face", {30'd0, SAT, FACE}, 32'd2);

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0001_0001;
    load_basic();
    launch(0, 100, 32'd0);
    repeat (5) @(posedge CLK);
    #2 RESET_N = 1'b0;
    m_on = 0;
    #1;
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_rd_en", 32'(RD_EN), 32'd0);
    chk("arst_result", RESULT, 32'd0);
    chk("arst_sat", 32'(SAT), 32'd0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    go(0, 4, 32'd0, 0);
    chk("post_rst_result", RESULT, 32'hFFFF_FFF9);
    chk("post_rst_latency", 32'(done_at - 1), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
